// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI responder (spi_slave and its synchroniser).
package spi_pkg;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } spi_state_t;

    localparam int SPI_WORD_W = 8;

    function automatic logic lead_is_rise(input logic cpol);
        return (cpol == 1'b0);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with a third stage producing registered rise/fall pulses (3 clk latency).
module spi_sync_edge #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;
    logic [WIDTH-1:0] last_r;
    logic [WIDTH-1:0] rise_r;
    logic [WIDTH-1:0] fall_r;

    // Resetting to the idle level keeps reset release from looking like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
            last_r <= RESET_VAL;
            rise_r <= {WIDTH{1'b0}};
            fall_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
            last_r <= sync_r;
            rise_r <= sync_r & ~last_r;
            fall_r <= ~sync_r & last_r;
        end
    end

    assign sync = sync_r;
    assign rise = rise_r;
    assign fall = fall_r;

endmodule

// File: rtl/spi_slave.sv
// Oversampled SPI responder, 8-bit MSB-first words with a one-entry reply holding register.
// Optional sticky underrun flag is built when SPI_SLAVE_UNDERRUN_EN is defined.
module spi_slave
    import spi_pkg::*;
#(
    parameter logic       cpol      = 1'b0,
    parameter logic       cpha      = 1'b0,
    parameter logic [7:0] idle_byte = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk_in,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [SPI_WORD_W-1:0] w_data_to_miso,
    input  logic                  w_valid,
    output logic                  w_ready,
    output logic [SPI_WORD_W-1:0] r_data_from_mosi,
    output logic                  data_ready,
    output logic                  busy,
    output logic                  underrun
);

    localparam int CNT_W = $clog2(SPI_WORD_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SPI_WORD_W - 1);

    logic sclk_sync_s, sclk_rise_s, sclk_fall_s;
    logic cs_sync_s, cs_rise_s, cs_fall_s;
    logic mosi_sync_s;
    logic [1:0] mosi_edge_unused_s;

    spi_sync_edge #(.WIDTH(1), .RESET_VAL(cpol)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(sclk_in),
        .sync(sclk_sync_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
    );

    spi_sync_edge #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .din(cs),
        .sync(cs_sync_s), .rise(cs_rise_s), .fall(cs_fall_s)
    );

    spi_sync_edge #(.WIDTH(1), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .din(mosi),
        .sync(mosi_sync_s), .rise(mosi_edge_unused_s[0]), .fall(mosi_edge_unused_s[1])
    );

    spi_state_t            state_r;
    logic [CNT_W-1:0]      bit_cnt_r;
    logic [SPI_WORD_W-1:0] tx_r;
    logic [SPI_WORD_W-1:0] rx_r;
    logic [SPI_WORD_W-1:0] hold_r;
    logic                  hold_full_r;
    logic                  miso_r;
    logic                  miso_oe_r;
    logic [SPI_WORD_W-1:0] r_data_r;
    logic                  data_ready_r;

    logic                  lead_s, trail_s, sample_s, shift_s;
    logic                  reload_s, accept_s;
    logic [SPI_WORD_W-1:0] load_byte_s;
    logic [SPI_WORD_W-1:0] rx_next_s;

    // Edge classification and reload/accept decisions for this clk.
    always_comb begin
        lead_s      = 1'b0;
        trail_s     = 1'b0;
        sample_s    = 1'b0;
        shift_s     = 1'b0;
        reload_s    = 1'b0;
        if (lead_is_rise(cpol)) begin
            lead_s  = sclk_rise_s;
            trail_s = sclk_fall_s;
        end else begin
            lead_s  = sclk_fall_s;
            trail_s = sclk_rise_s;
        end
        if (cpha == 1'b0) begin
            sample_s = lead_s;
            shift_s  = trail_s;
        end else begin
            sample_s = trail_s;
            shift_s  = lead_s;
        end
        accept_s    = w_valid & ~hold_full_r;
        load_byte_s = hold_full_r ? hold_r : idle_byte;
        rx_next_s   = {rx_r[SPI_WORD_W-2:0], mosi_sync_s};
        if (state_r == S_IDLE) begin
            reload_s = cs_fall_s;
        end else if (cs_rise_s) begin
            reload_s = 1'b0;
        end else begin
            reload_s = sample_s & (bit_cnt_r == LAST_BIT);
        end
    end

    // Frame FSM, shift registers, reply holding register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= S_IDLE;
            bit_cnt_r    <= {CNT_W{1'b0}};
            tx_r         <= {SPI_WORD_W{1'b0}};
            rx_r         <= {SPI_WORD_W{1'b0}};
            hold_r       <= {SPI_WORD_W{1'b0}};
            hold_full_r  <= 1'b0;
            miso_r       <= 1'b0;
            miso_oe_r    <= 1'b0;
            r_data_r     <= {SPI_WORD_W{1'b0}};
            data_ready_r <= 1'b0;
        end else begin
            data_ready_r <= 1'b0;
            miso_oe_r    <= ~cs_sync_s;
            // A reload in the same clk as a write drains the old value, never the new one.
            if (accept_s) begin
                hold_r      <= w_data_to_miso;
                hold_full_r <= 1'b1;
            end else if (reload_s && hold_full_r) begin
                hold_full_r <= 1'b0;
            end else begin
                hold_full_r <= hold_full_r;
            end
            case (state_r)
                S_IDLE: begin
                    miso_r    <= 1'b0;
                    bit_cnt_r <= {CNT_W{1'b0}};
                    if (cs_fall_s) begin
                        state_r <= S_SHIFT;
                        if (cpha == 1'b0) begin
                            miso_r <= load_byte_s[SPI_WORD_W-1];
                            tx_r   <= {load_byte_s[SPI_WORD_W-2:0], 1'b0};
                        end else begin
                            tx_r   <= load_byte_s;
                        end
                    end
                end
                S_SHIFT: begin
                    if (cs_rise_s) begin
                        state_r   <= S_IDLE;
                        bit_cnt_r <= {CNT_W{1'b0}};
                        miso_r    <= 1'b0;
                    end else begin
                        if (shift_s) begin
                            miso_r <= tx_r[SPI_WORD_W-1];
                            tx_r   <= {tx_r[SPI_WORD_W-2:0], 1'b0};
                        end
                        if (sample_s) begin
                            rx_r      <= rx_next_s;
                            bit_cnt_r <= bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                            if (bit_cnt_r == LAST_BIT) begin
                                r_data_r     <= rx_next_s;
                                data_ready_r <= 1'b1;
                                tx_r         <= load_byte_s;
                            end
                        end
                    end
                end
                default: begin
                    state_r   <= S_IDLE;
                    bit_cnt_r <= {CNT_W{1'b0}};
                    miso_r    <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPI_SLAVE_UNDERRUN_EN
    logic underrun_r;

    // Sticky: set when a reload has to fall back to idle_byte, cleared by the next accepted write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun_r <= 1'b0;
        end else if (reload_s && !hold_full_r) begin
            underrun_r <= 1'b1;
        end else if (accept_s) begin
            underrun_r <= 1'b0;
        end else begin
            underrun_r <= underrun_r;
        end
    end

    assign underrun = underrun_r;
`else
    assign underrun = 1'b0;
`endif

    assign miso             = miso_r;
    assign miso_oe          = miso_oe_r;
    assign w_ready          = ~hold_full_r;
    assign r_data_from_mosi = r_data_r;
    assign data_ready       = data_ready_r;
    assign busy             = (state_r == S_SHIFT);

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench: one responder per SPI mode, a byte-level master and a reply/receive model.
module tb_spi_slave;

    localparam int H = 8;   // sclk half period in clk cycles

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sclk_a = 4'b1100;
    logic [3:0] cs_a = 4'b1111;
    logic       mosi = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic [3:0] w_valid = 4'b0000;

    logic [3:0] miso_a, miso_oe_a, w_ready_a, data_ready_a, busy_a, underrun_a;
    logic [7:0] r_data_a [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave #(
            .cpol(g >= 2 ? 1'b1 : 1'b0),
            .cpha((g % 2) == 1 ? 1'b1 : 1'b0),
            .idle_byte(8'hFF)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .sclk_in(sclk_a[g]),
            .cs(cs_a[g]),
            .mosi(mosi),
            .miso(miso_a[g]),
            .miso_oe(miso_oe_a[g]),
            .w_data_to_miso(w_data),
            .w_valid(w_valid[g]),
            .w_ready(w_ready_a[g]),
            .r_data_from_mosi(r_data_a[g]),
            .data_ready(data_ready_a[g]),
            .busy(busy_a[g]),
            .underrun(underrun_a[g])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;
    int dr_cnt [4] = '{0, 0, 0, 0};

    // Reference model: one-deep reply slot, last received byte, underrun flag.
    logic [7:0] m_hold [4];
    bit         m_full [4];
    logic [7:0] m_rdata [4];
    bit         m_under [4];
    logic [7:0] tx_buf [4];

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (data_ready_a[i] === 1'b1) dr_cnt[i]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_full[i]  = 1'b0;
            m_hold[i]  = 8'h00;
            m_rdata[i] = 8'h00;
            m_under[i] = 1'b0;
        end
    endtask

    function automatic logic [7:0] model_pop(input int m);
        if (m_full[m]) begin
            m_full[m] = 1'b0;
            return m_hold[m];
        end
`ifdef SPI_SLAVE_UNDERRUN_EN
        m_under[m] = 1'b1;
`endif
        return 8'hFF;
    endfunction

    task automatic write_reply(input int m, input logic [7:0] v);
        check("w_ready_before", w_ready_a[m], 1);
        @(negedge clk);
        w_data     = v;
        w_valid[m] = 1'b1;
        @(negedge clk);
        w_valid[m] = 1'b0;
        m_full[m]  = 1'b1;
        m_hold[m]  = v;
        m_under[m] = 1'b0;
        check("w_ready_after", w_ready_a[m], 0);
        check("underrun_wr", underrun_a[m], m_under[m]);
    endtask

    // Master side of nbits bits, MSB first, in the mode of responder m.
    task automatic xfer(input int m, input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            if ((m % 2) == 0) begin
                mosi = tx[i];
                repeat (H) @(negedge clk);
                sclk_a[m] = ~sclk_a[m];
                rx[i] = miso_a[m];
                repeat (H) @(negedge clk);
                sclk_a[m] = ~sclk_a[m];
            end else begin
                sclk_a[m] = ~sclk_a[m];
                mosi = tx[i];
                repeat (H) @(negedge clk);
                sclk_a[m] = ~sclk_a[m];
                rx[i] = miso_a[m];
                repeat (H) @(negedge clk);
            end
        end
    endtask

    task automatic cs_low(input int m);
        check("oe_idle", miso_oe_a[m], 0);
        @(negedge clk);
        cs_a[m] = 1'b0;
        repeat (H) @(negedge clk);
        check("oe_frame", miso_oe_a[m], 1);
        check("busy_frame", busy_a[m], 1);
    endtask

    task automatic cs_high(input int m);
        repeat (H) @(negedge clk);
        cs_a[m] = 1'b1;
        repeat (8) @(negedge clk);
        check("busy_end", busy_a[m], 0);
        check("miso_end", miso_a[m], 0);
        check("oe_end", miso_oe_a[m], 0);
    endtask

    // n full bytes from tx_buf, then part_bits of tx_buf[n]; optional reply write after cs fall.
    task automatic run_frame(input int m, input int n, input int part_bits,
                             input bit wr_mid, input logic [7:0] wr_val);
        logic [7:0] rxb;
        logic [7:0] cur;
        int dr0;
        dr0 = dr_cnt[m];
        cs_low(m);
        cur = model_pop(m);
        if (wr_mid) write_reply(m, wr_val);
        for (int k = 0; k < n; k++) begin
            xfer(m, tx_buf[k], 8, rxb);
            check("master_rx", rxb, cur);
            m_rdata[m] = tx_buf[k];
            cur = model_pop(m);
        end
        if (part_bits > 0) xfer(m, tx_buf[n], part_bits, rxb);
        cs_high(m);
        check("data_ready_cnt", dr_cnt[m] - dr0, n);
        check("r_data", r_data_a[m], m_rdata[m]);
        check("underrun", underrun_a[m], m_under[m]);
        check("w_ready", w_ready_a[m], !m_full[m]);
    endtask

    initial begin
        logic [7:0] rxb;
        int m;
        int n;
        model_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("rst_w_ready", w_ready_a[i], 1);
            check("rst_outputs", {miso_a[i], miso_oe_a[i], data_ready_a[i], busy_a[i], underrun_a[i]}, 0);
            check("rst_r_data", r_data_a[i], 0);
        end
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // 1: mode 0, reply A5, receive 3C
        write_reply(0, 8'hA5);
        tx_buf[0] = 8'h3C;
        run_frame(0, 1, 0, 1'b0, 8'h00);

        // 2: mode 3, reply 81, receive 7E
        write_reply(3, 8'h81);
        tx_buf[0] = 8'h7E;
        run_frame(3, 1, 0, 1'b0, 8'h00);

        // 3: mode 1, reply 12 preloaded and 34 written once the slot frees, two bytes per frame
        write_reply(1, 8'h12);
        tx_buf[0] = 8'hF0;
        tx_buf[1] = 8'h0F;
        run_frame(1, 2, 0, 1'b1, 8'h34);

        // 4: mode 0, abort after 5 bits of AA, then a full frame of 55
        tx_buf[0] = 8'hAA;
        run_frame(0, 0, 5, 1'b0, 8'h00);
        tx_buf[0] = 8'h55;
        run_frame(0, 1, 0, 1'b0, 8'h00);

        // 5: mode 0 with nothing queued sends idle_byte; a write clears underrun
        tx_buf[0] = 8'h96;
        run_frame(0, 1, 0, 1'b0, 8'h00);
        write_reply(0, 8'h6B);

        // 6: asynchronous reset four bits into a byte
        cs_low(0);
        xfer(0, 8'h5A, 4, rxb);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_w_ready", w_ready_a[0], 1);
        check("midrst_outputs", {miso_a[0], miso_oe_a[0], data_ready_a[0], busy_a[0], underrun_a[0]}, 0);
        check("midrst_r_data", r_data_a[0], 0);
        model_reset();
        cs_a[0] = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        tx_buf[0] = 8'hC3;
        run_frame(0, 1, 0, 1'b0, 8'h00);

        // Randomised frames across all modes
        for (int it = 0; it < 14; it++) begin
            m = $urandom_range(3, 0);
            n = $urandom_range(3, 1);
            for (int k = 0; k < 4; k++) tx_buf[k] = 8'($urandom);
            if (!m_full[m] && ($urandom_range(1, 0) == 1)) write_reply(m, 8'($urandom));
            run_frame(m, n, ($urandom_range(3, 0) == 0) ? $urandom_range(7, 1) : 0,
                      1'($urandom_range(1, 0)), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
